// File: rtl/rr_grant_arbiter_pkg.sv
// Shared types and helpers for the round-robin grant arbiter.
package arb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  // Index width for n entries; never below one bit so N=1 still has a port.
  function automatic int unsigned clog2_safe(input int unsigned n);
    int unsigned w;
    for (w = 1; (32'd1 << w) < n; w++) begin
    end
    return w;
  endfunction

endpackage

// File: rtl/rr_grant_arbiter_if.sv
// Request/grant bundle between requesters (master) and the arbiter (slave).
interface rr_grant_arbiter_if #(
  parameter int unsigned N = 4
);
  import arb_pkg::*;

  localparam int unsigned IDX_W = clog2_safe(N);

  logic [N-1:0]     req;
  logic             done;
  logic             grant_valid;
  logic [N-1:0]     grant_oh;
  logic [IDX_W-1:0] grant_idx;

  modport master (
    output req,
    output done,
    input  grant_valid,
    input  grant_oh,
    input  grant_idx
  );

  modport slave (
    input  req,
    input  done,
    output grant_valid,
    output grant_oh,
    output grant_idx
  );

endinterface

// File: rtl/rr_grant_arbiter_onehot_to_bin.sv
// Parametrised one-hot to binary encoder: each index bit ORs the positions that carry it.
module onehot_to_bin
  import arb_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]                 oh,
  output logic [clog2_safe(N)-1:0]     idx
);

  localparam int unsigned IDX_W = clog2_safe(N);

  always_comb begin
    idx = '0;
    for (int unsigned i = 0; i < N; i++) begin
      for (int unsigned b = 0; b < IDX_W; b++) begin
        if (i[b]) idx[b] = idx[b] | oh[i];
      end
    end
  end

endmodule

// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter with registered one-hot/binary grant, held until the owner signals done.
module rr_grant_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic               clk,
  input  logic               resetn,
  rr_grant_arbiter_if.slave  bus
);

  localparam int unsigned            IDX_W    = clog2_safe(N);
  localparam logic [IDX_W-1:0]       LAST_RST = IDX_W'(N - 1);

  arb_state_t       state, state_nxt;
  logic [IDX_W-1:0] last, last_nxt;
  logic             valid_nxt;
  logic [N-1:0]     oh_nxt;
  logic [IDX_W-1:0] idx_nxt;

  logic [N-1:0]     others;
  logic [N-1:0]     pick_req;
  logic [IDX_W-1:0] pick_ptr;
  logic [IDX_W:0]   rot_amt;
  logic [2*N-1:0]   dbl_req;
  logic [2*N-1:0]   dbl_ffo;
  logic [N-1:0]     rot_req;
  logic [N-1:0]     rot_ffo;
  logic [N-1:0]     win_oh;
  logic [IDX_W-1:0] win_idx;

  assign others = bus.req & ~bus.grant_oh;

  // Rotate so the slot after the pointer lands at bit 0, isolate the lowest set
  // bit, then rotate back; the doubled vector makes both rotations plain shifts.
  always_comb begin
    pick_req = (state == ARB_IDLE) ? bus.req : others;
    pick_ptr = (state == ARB_IDLE) ? last    : bus.grant_idx;
    rot_amt  = {1'b0, pick_ptr} + 1'b1;
    dbl_req  = {pick_req, pick_req} >> rot_amt;
    rot_req  = dbl_req[N-1:0];
    rot_ffo  = rot_req & (~rot_req + N'(1));
    dbl_ffo  = {rot_ffo, rot_ffo} << rot_amt;
    win_oh   = dbl_ffo[2*N-1:N];
  end

  onehot_to_bin #(.N(N)) u_enc (
    .oh  (win_oh),
    .idx (win_idx)
  );

  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    valid_nxt = bus.grant_valid;
    oh_nxt    = bus.grant_oh;
    idx_nxt   = bus.grant_idx;
    case (state)
      ARB_IDLE: begin
        if (|bus.req) begin
          valid_nxt = 1'b1;
          oh_nxt    = win_oh;
          idx_nxt   = win_idx;
          state_nxt = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        if (bus.done) begin
          last_nxt = bus.grant_idx;
          if (|others) begin
            oh_nxt  = win_oh;
            idx_nxt = win_idx;
          end else begin
            valid_nxt = 1'b0;
            oh_nxt    = '0;
            idx_nxt   = '0;
            state_nxt = ARB_IDLE;
          end
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state           <= ARB_IDLE;
      last            <= LAST_RST;
      bus.grant_valid <= 1'b0;
      bus.grant_oh    <= '0;
      bus.grant_idx   <= '0;
    end else begin
      state           <= state_nxt;
      last            <= last_nxt;
      bus.grant_valid <= valid_nxt;
      bus.grant_oh    <= oh_nxt;
      bus.grant_idx   <= idx_nxt;
    end
  end

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Self-checking bench for rr_grant_arbiter at N=4, N=5 and N=1 against a behavioural model.
module tb_rr_grant_arbiter;

  logic clk = 1'b0;
  logic resetn;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  rr_grant_arbiter_if #(.N(4)) if4 ();
  rr_grant_arbiter_if #(.N(5)) if5 ();
  rr_grant_arbiter_if #(.N(1)) if1 ();

  rr_grant_arbiter #(.N(4)) dut4 (.clk(clk), .resetn(resetn), .bus(if4));
  rr_grant_arbiter #(.N(5)) dut5 (.clk(clk), .resetn(resetn), .bus(if5));
  rr_grant_arbiter #(.N(1)) dut1 (.clk(clk), .resetn(resetn), .bus(if1));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Mid-cycle reset pulse, well clear of the rising edge.
  task automatic do_reset();
    #2 resetn = 1'b0;
    #3 resetn = 1'b1;
  endtask

  // First requester after p, scanning upward modulo n; -1 when none.
  function automatic int pick(input int unsigned r, input int p, input int n);
    for (int k = 1; k <= n; k++) begin
      int i;
      i = (p + k) % n;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_step(input int n, input int unsigned r, input bit d,
                            inout bit v, inout int o, inout int l);
    int unsigned rest;
    if (!v) begin
      if (r != 0) begin
        o = pick(r, l, n);
        v = 1'b1;
      end
    end else if (d) begin
      l = o;
      rest = r & ~(32'd1 << o);
      if (rest != 0) o = pick(rest, o, n);
      else v = 1'b0;
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    if4.req = 'x; if4.done = 'x;
    if5.req = 'x; if5.done = 'x;
    if1.req = 'x; if1.done = 'x;
    tick(); tick();
    checks++;
    if ({if4.grant_valid, if4.grant_oh, if4.grant_idx} !== 7'b0) begin
      failures++;
      $display("FAIL reset_n4: got v=%b oh=%b idx=%0d, expected all zero",
               if4.grant_valid, if4.grant_oh, if4.grant_idx);
    end
    checks++;
    if ({if5.grant_valid, if5.grant_oh, if5.grant_idx} !== 9'b0) begin
      failures++;
      $display("FAIL reset_n5: got v=%b oh=%b idx=%0d, expected all zero",
               if5.grant_valid, if5.grant_oh, if5.grant_idx);
    end
    checks++;
    if ({if1.grant_valid, if1.grant_oh, if1.grant_idx} !== 3'b0) begin
      failures++;
      $display("FAIL reset_n1: got v=%b oh=%b idx=%0d, expected all zero",
               if1.grant_valid, if1.grant_oh, if1.grant_idx);
    end
    if4.req = '0; if4.done = 1'b0;
    if5.req = '0; if5.done = 1'b0;
    if1.req = '0; if1.done = 1'b0;
    #2 resetn = 1'b1;
    tick();
    checks++;
    if (if4.grant_valid !== 1'b0 || if4.grant_oh !== 4'b0) begin
      failures++;
      $display("FAIL idle_after_reset: got v=%b oh=%b, expected v=0 oh=0000",
               if4.grant_valid, if4.grant_oh);
    end
  endtask

  task automatic test_rr_sequence();
    if4.req = 4'b1111;
    if4.done = 1'b0;
    tick();
    for (int k = 0; k < 5; k++) begin
      int unsigned ex;
      ex = k % 4;
      checks++;
      if (if4.grant_valid !== 1'b1 || if4.grant_oh !== 4'(32'd1 << ex) || if4.grant_idx !== 2'(ex)) begin
        failures++;
        $display("FAIL rr_seq[%0d]: got v=%b oh=%b idx=%0d, expected v=1 oh=%b idx=%0d",
                 k, if4.grant_valid, if4.grant_oh, if4.grant_idx, 4'(32'd1 << ex), ex);
      end
      if (k == 4) if4.req = '0;
      if4.done = 1'b1;
      tick();
    end
    checks++;
    if (if4.grant_valid !== 1'b0 || if4.grant_oh !== 4'b0 || if4.grant_idx !== 2'd0) begin
      failures++;
      $display("FAIL rr_seq_drop: got v=%b oh=%b idx=%0d, expected all zero",
               if4.grant_valid, if4.grant_oh, if4.grant_idx);
    end
    if4.done = 1'b0;
  endtask

  task automatic test_hold();
    if4.req = 4'b0100;
    tick();
    if4.req = 4'b0000;
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (if4.grant_valid !== 1'b1 || if4.grant_oh !== 4'b0100 || if4.grant_idx !== 2'd2) begin
        failures++;
        $display("FAIL hold[%0d]: got v=%b oh=%b idx=%0d, expected v=1 oh=0100 idx=2",
                 c, if4.grant_valid, if4.grant_oh, if4.grant_idx);
      end
      tick();
    end
    if4.done = 1'b1;
    tick();
    if4.done = 1'b0;
    checks++;
    if (if4.grant_valid !== 1'b0 || if4.grant_oh !== 4'b0) begin
      failures++;
      $display("FAIL hold_release: got v=%b oh=%b, expected v=0 oh=0000",
               if4.grant_valid, if4.grant_oh);
    end
  endtask

  task automatic test_regrant();
    if4.req = 4'b1000;
    tick();
    checks++;
    if (if4.grant_valid !== 1'b1 || if4.grant_oh !== 4'b1000 || if4.grant_idx !== 2'd3) begin
      failures++;
      $display("FAIL regrant_first: got v=%b oh=%b idx=%0d, expected v=1 oh=1000 idx=3",
               if4.grant_valid, if4.grant_oh, if4.grant_idx);
    end
    if4.done = 1'b1;
    tick();
    if4.done = 1'b0;
    checks++;
    if (if4.grant_valid !== 1'b0 || if4.grant_oh !== 4'b0) begin
      failures++;
      $display("FAIL regrant_gap: got v=%b oh=%b, expected v=0 oh=0000",
               if4.grant_valid, if4.grant_oh);
    end
    tick();
    checks++;
    if (if4.grant_valid !== 1'b1 || if4.grant_oh !== 4'b1000 || if4.grant_idx !== 2'd3) begin
      failures++;
      $display("FAIL regrant_again: got v=%b oh=%b idx=%0d, expected v=1 oh=1000 idx=3",
               if4.grant_valid, if4.grant_oh, if4.grant_idx);
    end
    if4.req = '0;
    if4.done = 1'b1;
    tick();
    if4.done = 1'b0;
  endtask

  task automatic test_npot();
    int unsigned exp_idx [3] = '{0, 4, 0};
    if5.req = 5'b10001;
    if5.done = 1'b0;
    tick();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (if5.grant_valid !== 1'b1 || if5.grant_idx !== 3'(exp_idx[k]) ||
          if5.grant_oh !== 5'(32'd1 << exp_idx[k]) || if5.grant_idx > 3'd4) begin
        failures++;
        $display("FAIL npot[%0d]: got v=%b oh=%b idx=%0d, expected v=1 idx=%0d",
                 k, if5.grant_valid, if5.grant_oh, if5.grant_idx, exp_idx[k]);
      end
      if5.done = 1'b1;
      tick();
    end
    if5.req = '0;
    tick();
    if5.done = 1'b0;
  endtask

  task automatic test_async_reset();
    if4.req = 4'b0100;
    tick();
    #2 resetn = 1'b0;
    #1;
    checks++;
    if ({if4.grant_valid, if4.grant_oh, if4.grant_idx} !== 7'b0) begin
      failures++;
      $display("FAIL async_reset: got v=%b oh=%b idx=%0d, expected all zero",
               if4.grant_valid, if4.grant_oh, if4.grant_idx);
    end
    if4.req = 4'b0110;
    #2 resetn = 1'b1;
    tick();
    checks++;
    if (if4.grant_valid !== 1'b1 || if4.grant_oh !== 4'b0010 || if4.grant_idx !== 2'd1) begin
      failures++;
      $display("FAIL after_async_reset: got v=%b oh=%b idx=%0d, expected v=1 oh=0010 idx=1",
               if4.grant_valid, if4.grant_oh, if4.grant_idx);
    end
    if4.req = '0;
    if4.done = 1'b1;
    tick();
    if4.done = 1'b0;
  endtask

  task automatic test_single();
    bit v = 1'b0;
    int o = 0;
    int l = 0;
    if1.req = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if1.done = (i % 2 == 1);
      model_step(1, 1, if1.done, v, o, l);
      tick();
      checks++;
      if (if1.grant_valid !== v || if1.grant_oh !== v || if1.grant_idx !== 1'b0) begin
        failures++;
        $display("FAIL single[%0d]: got v=%b oh=%b idx=%0d, expected v=%b oh=%b idx=0",
                 i, if1.grant_valid, if1.grant_oh, if1.grant_idx, v, v);
      end
    end
    if1.req = 1'b0;
    if1.done = 1'b0;
  endtask

  task automatic test_random();
    bit v4 = 1'b0, v5 = 1'b0;
    int o4 = 0, o5 = 0;
    int l4 = 3, l5 = 4;
    logic [3:0] e_oh4;
    logic [4:0] e_oh5;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if4.req  = 4'($urandom_range(0, 15));
      if4.done = ($urandom_range(0, 2) == 0);
      if5.req  = 5'($urandom_range(0, 31));
      if5.done = ($urandom_range(0, 2) == 0);
      model_step(4, 32'(if4.req), if4.done, v4, o4, l4);
      model_step(5, 32'(if5.req), if5.done, v5, o5, l5);
      tick();
      e_oh4 = v4 ? 4'(32'd1 << o4) : 4'b0;
      e_oh5 = v5 ? 5'(32'd1 << o5) : 5'b0;
      checks++;
      if (if4.grant_valid !== v4 || if4.grant_oh !== e_oh4 || if4.grant_idx !== (v4 ? 2'(o4) : 2'd0)) begin
        failures++;
        $display("FAIL rand_n4[%0d]: got v=%b oh=%b idx=%0d, expected v=%b oh=%b idx=%0d",
                 i, if4.grant_valid, if4.grant_oh, if4.grant_idx, v4, e_oh4, v4 ? o4 : 0);
      end
      checks++;
      if (if5.grant_valid !== v5 || if5.grant_oh !== e_oh5 || if5.grant_idx !== (v5 ? 3'(o5) : 3'd0)) begin
        failures++;
        $display("FAIL rand_n5[%0d]: got v=%b oh=%b idx=%0d, expected v=%b oh=%b idx=%0d",
                 i, if5.grant_valid, if5.grant_oh, if5.grant_idx, v5, e_oh5, v5 ? o5 : 0);
      end
    end
    if4.req = '0; if4.done = 1'b0;
    if5.req = '0; if5.done = 1'b0;
  endtask

  initial begin
    test_reset();
    test_rr_sequence();
    test_hold();
    test_regrant();
    test_npot();
    test_async_reset();
    test_single();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
